uart_word_bridge: RTL and testbench

//   Bridges a byte-wide UART (RX FIFO / TX port) to the interpreter's 32-bit word handshake.

---
 rtl/uart_word_bridge.sv | 181 ++++++++++++++++++
 tb/tb_uart_word_bridge.sv | 549 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge.sv
// Bridges a byte-wide UART RX FIFO / TX port to a 32-bit word handshake.
// RX bytes are assembled LSB first into a held word; TX words are sent as 4 bytes LSB first.
module uart_word_bridge #(
    parameter int unsigned RX_TIMEOUT_CYCLES = 250000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_byte_valid,
    input  logic [7:0]  i_rx_byte,
    output logic        o_rx_byte_read,
    input  logic        i_tx_byte_ready,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_byte_write,
    output logic        o_rx_empty,
    input  logic        i_read,
    output logic        o_read_response,
    output logic [31:0] o_read_data,
    output logic        o_tx_empty,
    input  logic        i_write,
    input  logic [31:0] i_write_data,
    output logic        o_write_response,
    output logic        o_rx_resync
);

    localparam logic [31:0] TimeoutLast = 32'(RX_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {HEmpty, HFull, HResp, HWait} hold_state_e;
    typedef enum logic [1:0] {TIdle, TSend, TDone} tx_state_e;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [31:0] r_shift;
    logic [1:0]  r_count;
    logic [31:0] r_timer;
    logic        r_pop;
    logic        r_resync;
    hold_state_e r_hstate;
    logic [31:0] r_hold;
    logic        r_rx_empty;
    logic        r_read_response;
    logic        w_pop;
    logic        w_load;

    // The 4th byte stays in the FIFO until the hold register is free.
    assign w_pop  = w_rst_n && i_rx_byte_valid && !r_pop &&
                    ((r_count != 2'd3) || (r_hstate == HEmpty));
    assign w_load = w_pop && (r_count == 2'd3);

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shift  <= 32'h0;
            r_count  <= 2'd0;
            r_timer  <= 32'h0;
            r_pop    <= 1'b0;
            r_resync <= 1'b0;
        end else begin
            r_pop    <= w_pop;
            r_resync <= 1'b0;
            if (w_pop) begin
                r_shift <= {i_rx_byte, r_shift[31:8]};
                r_count <= r_count + 2'd1;
                r_timer <= 32'h0;
            end else if (r_count != 2'd0) begin
                if (r_timer == TimeoutLast) begin
                    r_count  <= 2'd0;
                    r_timer  <= 32'h0;
                    r_resync <= 1'b1;
                end else begin
                    r_timer <= r_timer + 32'd1;
                end
            end
        end
    end

    // HWait swallows a read level that outlives its response.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hstate        <= HEmpty;
            r_hold          <= 32'h0;
            r_rx_empty      <= 1'b1;
            r_read_response <= 1'b0;
        end else begin
            r_read_response <= 1'b0;
            case (r_hstate)
                HEmpty: begin
                    if (w_load) begin
                        r_hold     <= {i_rx_byte, r_shift[31:8]};
                        r_rx_empty <= 1'b0;
                        r_hstate   <= HFull;
                    end
                end
                HFull: begin
                    if (i_read) begin
                        r_read_response <= 1'b1;
                        r_rx_empty      <= 1'b1;
                        r_hstate        <= HResp;
                    end
                end
                HResp: r_hstate <= HWait;
                HWait: begin
                    if (!i_read) begin
                        r_hstate <= HEmpty;
                    end
                end
                default: r_hstate <= HEmpty;
            endcase
        end
    end

    tx_state_e   r_tstate;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [7:0]  r_tx_byte;
    logic        r_tx_byte_write;
    logic        r_tx_empty;
    logic        r_write_response;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tstate         <= TIdle;
            r_word           <= 32'h0;
            r_idx            <= 2'd0;
            r_tx_byte        <= 8'h0;
            r_tx_byte_write  <= 1'b0;
            r_tx_empty       <= 1'b1;
            r_write_response <= 1'b0;
        end else begin
            r_tx_byte_write  <= 1'b0;
            r_write_response <= 1'b0;
            case (r_tstate)
                TIdle: begin
                    if (i_write) begin
                        r_word     <= i_write_data;
                        r_idx      <= 2'd0;
                        r_tx_empty <= 1'b0;
                        r_tstate   <= TSend;
                    end
                end
                TSend: begin
                    if (i_tx_byte_ready && !r_tx_byte_write) begin
                        r_tx_byte_write <= 1'b1;
                        r_tx_byte       <= r_word[{r_idx, 3'b000} +: 8];
                        r_idx           <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_tstate <= TDone;
                        end
                    end
                end
                TDone: begin
                    r_write_response <= 1'b1;
                    r_tx_empty       <= 1'b1;
                    r_tstate         <= TIdle;
                end
                default: r_tstate <= TIdle;
            endcase
        end
    end

    assign o_rx_byte_read   = w_pop;
    assign o_rx_resync      = r_resync;
    assign o_rx_empty       = r_rx_empty;
    assign o_read_response  = r_read_response;
    assign o_read_data      = r_hold;
    assign o_tx_byte        = r_tx_byte;
    assign o_tx_byte_write  = r_tx_byte_write;
    assign o_tx_empty       = r_tx_empty;
    assign o_write_response = r_write_response;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Scoreboard bench for uart_word_bridge: RX FIFO model, TX byte capture, one task per scenario.
module tb_uart_word_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_rx_byte_valid;
    logic [7:0]  i_rx_byte;
    logic        o_rx_byte_read;
    logic        i_tx_byte_ready;
    logic [7:0]  o_tx_byte;
    logic        o_tx_byte_write;
    logic        o_rx_empty;
    logic        i_read;
    logic        o_read_response;
    logic [31:0] o_read_data;
    logic        o_tx_empty;
    logic        i_write;
    logic [31:0] i_write_data;
    logic        o_write_response;
    logic        o_rx_resync;

    uart_word_bridge #(.RX_TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_byte_valid(i_rx_byte_valid), .i_rx_byte(i_rx_byte), .o_rx_byte_read(o_rx_byte_read),
        .i_tx_byte_ready(i_tx_byte_ready), .o_tx_byte(o_tx_byte), .o_tx_byte_write(o_tx_byte_write),
        .o_rx_empty(o_rx_empty), .i_read(i_read), .o_read_response(o_read_response),
        .o_read_data(o_read_data), .o_tx_empty(o_tx_empty), .i_write(i_write),
        .i_write_data(i_write_data), .o_write_response(o_write_response),
        .o_rx_resync(o_rx_resync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rxq[$];
    logic [31:0] exp_rx[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];

    int          n_resp = 0, n_wresp = 0, n_resync = 0, n_pops = 0, n_b2b = 0, cyc = 0;
    int          last_pop_cyc = 0, last_resync_cyc = 0, last_wresp_cyc = 0;
    logic [31:0] last_resp_data = 32'h0;
    bit          prev_strobe = 1'b0;
    bit          rand_gap = 1'b0;
    bit          fifo_pend;

    always @(negedge clk) begin
        cyc++;
        if (o_read_response) begin
            n_resp++;
            last_resp_data = o_read_data;
        end
        if (o_write_response) begin
            n_wresp++;
            last_wresp_cyc = cyc;
        end
        if (o_rx_resync) begin
            n_resync++;
            last_resync_cyc = cyc;
        end
        if (o_rx_byte_read) begin
            n_pops++;
            last_pop_cyc = cyc;
        end
        if (o_tx_byte_write) begin
            got_tx.push_back(o_tx_byte);
            if (prev_strobe) n_b2b++;
        end
        prev_strobe = o_tx_byte_write;
    end

    // First-word-fall-through RX FIFO model.
    initial begin
        i_rx_byte_valid = 1'b0;
        i_rx_byte       = 8'h00;
        forever begin
            @(negedge clk);
            fifo_pend = o_rx_byte_read;
            @(posedge clk);
            #2;
            if (fifo_pend && rxq.size() > 0) rxq.delete(0);
            if (rxq.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                i_rx_byte_valid = 1'b1;
                i_rx_byte       = rxq[0];
            end else begin
                i_rx_byte_valid = 1'b0;
                i_rx_byte       = 8'h00;
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input bit expect_it);
        for (int k = 0; k < 4; k++) rxq.push_back(w[8*k +: 8]);
        if (expect_it) exp_rx.push_back(w);
    endtask

    task automatic wait_rx_full(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #1;
            if (o_rx_empty === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pops(input int base, input int want, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #1;
            if (n_pops - base >= want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_read(output bit ok);
        int r0;
        r0 = n_resp;
        ok = 1'b0;
        @(posedge clk);
        #1;
        i_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (n_resp != r0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    function automatic logic [31:0] next_exp_rx();
        if (exp_rx.size() == 0) return 32'hxxxxxxxx;
        return exp_rx.pop_front();
    endfunction

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_rx_empty, o_tx_empty, o_rx_byte_read, o_tx_byte_write, o_read_response,
             o_write_response, o_rx_resync} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 1100000", {o_rx_empty, o_tx_empty,
                     o_rx_byte_read, o_tx_byte_write, o_read_response, o_write_response,
                     o_rx_resync});
        end
        checks++;
        if ({o_read_data, o_tx_byte} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0", {o_read_data, o_tx_byte});
        end
        @(negedge clk);
        i_reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({o_rx_empty, o_tx_empty, o_tx_byte_write, o_read_response} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_release: got %b required 1100",
                     {o_rx_empty, o_tx_empty, o_tx_byte_write, o_read_response});
        end
    endtask

    task automatic test_rx_basic();
        bit ok;
        int r0;
        logic [31:0] e;
        rand_gap = 1'b1;
        push_word(32'h0000_0070, 1'b1);
        wait_rx_full(200, ok);
        rand_gap = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rx1_ready: rx_empty 1 required 0");
        end
        @(posedge clk);
        #1;
        r0 = n_resp;
        i_read = 1'b1;
        @(negedge clk);
        checks++;
        if (o_read_response !== 1'b0) begin
            failures++;
            $display("FAIL rx1_early: read_response %b required 0", o_read_response);
        end
        @(negedge clk);
        e = next_exp_rx();
        checks++;
        if ({o_read_response, o_rx_empty, o_read_data} !== {2'b11, e}) begin
            failures++;
            $display("FAIL rx1_resp: resp/empty/data %b/%b/%h required 1/1/%h",
                     o_read_response, o_rx_empty, o_read_data, e);
        end
        repeat (2) @(posedge clk);
        #1;
        i_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_resp - r0 != 1) begin
            failures++;
            $display("FAIL rx1_count: responses %0d required 1", n_resp - r0);
        end
    endtask

    task automatic test_tx_basic();
        int w0, b0, wc;
        bit ok;
        logic [7:0] e;
        i_tx_byte_ready = 1'b1;
        @(posedge clk);
        #1;
        got_tx.delete();
        exp_tx.delete();
        for (int k = 0; k < 4; k++) exp_tx.push_back(k == 0 ? 8'h6A : 8'h00);
        w0 = n_wresp;
        b0 = n_b2b;
        i_write = 1'b1;
        i_write_data = 32'h0000_006A;
        @(negedge clk);
        #1;
        wc = cyc;
        @(posedge clk);
        #1;
        i_write = 1'b1;
        i_write_data = 32'hDEAD_BEEF;
        checks++;
        if (o_tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL tx_busy: tx_empty %b required 0", o_tx_empty);
        end
        @(posedge clk);
        #1;
        i_write = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (n_wresp != w0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || last_wresp_cyc - wc != 9) begin
            failures++;
            $display("FAIL tx_latency: seen %0d cycles %0d required 1 and 9", ok,
                     last_wresp_cyc - wc);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (got_tx.size() != 4) begin
            failures++;
            $display("FAIL tx_count: bytes %0d required 4", got_tx.size());
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_tx.pop_front();
            checks++;
            if (got_tx.size() <= k || got_tx[k] !== e) begin
                failures++;
                $display("FAIL tx_byte%0d: got %h required %h", k,
                         got_tx.size() > k ? got_tx[k] : 8'hxx, e);
            end
        end
        checks++;
        if (n_b2b != b0 || n_wresp - w0 != 1 || o_tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL tx_done: b2b %0d wresp %0d tx_empty %b required 0 1 1",
                     n_b2b - b0, n_wresp - w0, o_tx_empty);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        bit ok;
        logic [31:0] e;
        p0 = n_pops;
        push_word(32'hA1A2_A3A4, 1'b1);
        push_word(32'hB1B2_B3B4, 1'b1);
        wait_pops(p0, 7, 40, ok);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (!ok || n_pops - p0 != 7 || o_rx_empty !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: pops %0d rx_empty %b required 7 0", n_pops - p0, o_rx_empty);
        end
        do_read(ok);
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL bp_word1: data %h required %h", last_resp_data, e);
        end
        wait_rx_full(12, ok);
        checks++;
        if (!ok || n_pops - p0 != 8) begin
            failures++;
            $display("FAIL bp_pop8: pops %0d required 8", n_pops - p0);
        end
        do_read(ok);
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL bp_word2: data %h required %h", last_resp_data, e);
        end
    endtask

    task automatic test_timeout();
        int p0, s0;
        bit ok;
        logic [31:0] e;
        p0 = n_pops;
        s0 = n_resync;
        rxq.push_back(8'hAB);
        rxq.push_back(8'hCD);
        wait_pops(p0, 2, 20, ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (n_resync != s0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || last_resync_cyc - last_pop_cyc != 17) begin
            failures++;
            $display("FAIL to_resync: seen %0d after %0d cycles required 1 after 17", ok,
                     last_resync_cyc - last_pop_cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_resync - s0 != 1 || o_rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL to_pulse: pulses %0d rx_empty %b required 1 1", n_resync - s0,
                     o_rx_empty);
        end
        push_word(32'h4433_2211, 1'b1);
        wait_rx_full(40, ok);
        do_read(ok);
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL to_word: data %h required %h", last_resp_data, e);
        end
    endtask

    task automatic test_reset_mid_tx();
        int w0, g0;
        bit ok;
        i_tx_byte_ready = 1'b1;
        w0 = n_wresp;
        g0 = got_tx.size();
        @(posedge clk);
        #1;
        i_write = 1'b1;
        i_write_data = 32'h1122_3344;
        @(posedge clk);
        #1;
        i_write = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (got_tx.size() - g0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if (!ok || {o_tx_empty, o_tx_byte_write, o_write_response, o_rx_empty, o_read_response,
                    o_tx_byte} !== {5'b10010, 8'h00}) begin
            failures++;
            $display("FAIL rst_mid: seen %0d empty/wr/resp/rxe/rresp/byte %b%b%b%b%b/%h required 10010/00",
                     ok, o_tx_empty, o_tx_byte_write, o_write_response, o_rx_empty,
                     o_read_response, o_tx_byte);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_tx.size() - g0 != 2 || n_wresp != w0 || o_tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL rst_abort: bytes %0d wresp %0d tx_empty %b required 2 0 1",
                     got_tx.size() - g0, n_wresp - w0, o_tx_empty);
        end
    endtask

    task automatic test_read_held();
        int p0, r0;
        bit ok;
        logic [31:0] e;
        p0 = n_pops;
        push_word(32'hC0DE_0001, 1'b1);
        push_word(32'hC0DE_0002, 1'b1);
        wait_pops(p0, 7, 40, ok);
        @(posedge clk);
        #1;
        r0 = n_resp;
        i_read = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (n_resp != r0) begin
                ok = 1'b1;
                break;
            end
        end
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL held_word1: data %h required %h", last_resp_data, e);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_resp - r0 != 1 || n_pops - p0 != 7) begin
            failures++;
            $display("FAIL held_single: responses %0d pops %0d required 1 7", n_resp - r0,
                     n_pops - p0);
        end
        i_read = 1'b0;
        @(posedge clk);
        #1;
        i_read = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (n_resp - r0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL held_word2: data %h required %h", last_resp_data, e);
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    task automatic test_concurrent();
        int g0, w0;
        bit ok;
        logic [31:0] e;
        logic [31:0] tw;
        tw = 32'hA1B2_C3D4;
        i_tx_byte_ready = 1'b0;
        g0 = got_tx.size();
        w0 = n_wresp;
        @(posedge clk);
        #1;
        i_write = 1'b1;
        i_write_data = tw;
        push_word(32'h55AA_1234, 1'b1);
        @(posedge clk);
        #1;
        i_write = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_tx.size() != g0) begin
            failures++;
            $display("FAIL cc_stall: bytes %0d required 0", got_tx.size() - g0);
        end
        i_tx_byte_ready = 1'b1;
        do_read(ok);
        e = next_exp_rx();
        checks++;
        if (!ok || last_resp_data !== e) begin
            failures++;
            $display("FAIL cc_rx: data %h required %h", last_resp_data, e);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (got_tx.size() - g0 != 4 || n_wresp - w0 != 1) begin
            failures++;
            $display("FAIL cc_tx: bytes %0d wresp %0d required 4 1", got_tx.size() - g0,
                     n_wresp - w0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_tx[g0 + k] !== tw[8*k +: 8]) begin
                    failures++;
                    $display("FAIL cc_byte%0d: got %h required %h", k, got_tx[g0 + k],
                             tw[8*k +: 8]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0;
        i_read = 1'b0;
        i_write = 1'b0;
        i_write_data = 32'h0;
        i_tx_byte_ready = 1'b1;
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_backpressure();
        test_timeout();
        test_reset_mid_tx();
        test_read_held();
        test_concurrent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
